misr_sig_collector: RTL

- Type-parameterized result sink and signature checker: accepts a stream of typed payload beats over valid/ready and folds them into a 64-bit MISR.
- Uses the same polynomial as the team's self-checking benches: next = data_zext ^ {sum[62:0], sum[63]^sum[2]^sum[0]}.
- It is the consuming end of the CRC-driven stimulus path. It replaces the hand-written "sum" logic in bench tops, and compares the final signature against an expected value.

---
 rtl/misr_pkg.sv | 20 ++
 rtl/misr_beat_counter.sv | 35 +++
 rtl/misr_sig_collector.sv | 135 +++++++++++++
 3 files changed

// File: rtl/misr_pkg.sv
// Shared types and the 64-bit MISR step used by the signature collector.
package misr_pkg;

  localparam int unsigned MISR_W = 64;

  typedef logic [MISR_W-1:0] misr_t;

  typedef enum logic [1:0] {
    StIdle,
    StWarmup,
    StAccum,
    StDone
  } state_t;

  // Same polynomial as the self-checking bench tops: shift left, feedback taps 63/2/0.
  function automatic misr_t misr_next(misr_t sum, misr_t data);
    return data ^ {sum[MISR_W-2:0], sum[MISR_W-1] ^ sum[2] ^ sum[0]};
  endfunction

endpackage

// File: rtl/misr_beat_counter.sv
// Beat counter with synchronous clear and a flag marking the beat that reaches the limit.
module misr_beat_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [Width-1:0] limit,
  output logic             last
);

  logic [Width-1:0] cnt_q, cnt_d;

  // Compared one bit wider so cnt_q + 1 cannot wrap before the compare.
  assign last = inc && (({1'b0, cnt_q} + 1'b1) == {1'b0, limit});

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/misr_sig_collector.sv
// Stream sink folding typed payload beats into a 64-bit MISR and checking the final signature.
// Define MISR_SIG_FINISH_EN to print the signature and end simulation on completion.
module misr_sig_collector
  import misr_pkg::*;
#(
  parameter type         p_t      = logic [2:0],
  parameter int unsigned WARMUP   = 10,
  parameter int unsigned COUNT    = 80,
  parameter misr_t       SEED     = 64'h0,
  parameter misr_t       EXPECTED = 64'h0
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  start,
  input  logic  in_valid,
  output logic  in_ready,
  input  p_t    in_data,
  output misr_t sum,
  output logic  busy,
  output logic  done,
  output logic  pass
);

  localparam int unsigned PW       = $bits(p_t);
  localparam int unsigned MaxBeats = (WARMUP > COUNT) ? WARMUP : COUNT;
  localparam int unsigned CntW     = $clog2(MaxBeats + 1);

  if (PW < 1 || PW > MISR_W) begin : g_bad_width
    $error("misr_sig_collector: $bits(p_t) must be 1..64");
  end
  if (COUNT < 1) begin : g_bad_count
    $error("misr_sig_collector: COUNT must be >= 1");
  end

  state_t            state_q, state_d;
  misr_t             sum_q, sum_d;
  logic              pass_q, pass_d;
  misr_t             data_zext;
  logic              accept;
  logic              cnt_clr, cnt_inc, cnt_last;
  logic [CntW-1:0]   cnt_limit;

  assign in_ready = (state_q == StWarmup) || (state_q == StAccum);
  assign accept   = in_valid && in_ready;
  assign busy     = in_ready;
  assign done     = (state_q == StDone);
  assign pass     = done && pass_q;
  assign sum      = sum_q;

  // Zero-extend regardless of the signedness of p_t.
  always_comb begin
    data_zext         = '0;
    data_zext[PW-1:0] = in_data;
  end

  assign cnt_limit = (state_q == StWarmup) ? CntW'(WARMUP) : CntW'(COUNT);

  misr_beat_counter #(
    .Width (CntW)
  ) u_beat_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .limit (cnt_limit),
    .last  (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    pass_d  = pass_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          sum_d   = SEED;
          pass_d  = 1'b0;
          cnt_clr = 1'b1;
          state_d = (WARMUP > 0) ? StWarmup : StAccum;
        end
      end
      StWarmup: begin
        if (accept) begin
          cnt_inc = 1'b1;
          if (cnt_last) begin
            cnt_clr = 1'b1;
            state_d = StAccum;
          end
        end
      end
      StAccum: begin
        if (accept) begin
          cnt_inc = 1'b1;
          sum_d   = misr_next(sum_q, data_zext);
          if (cnt_last) begin
            cnt_clr = 1'b1;
            pass_d  = (sum_d == EXPECTED);
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      sum_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      pass_q  <= pass_d;
    end
  end

`ifdef MISR_SIG_FINISH_EN
  always @(posedge clk) begin
    if (rst_n && state_q == StAccum && state_d == StDone) begin
      $display("[%0t] sum=%x", $time, sum_d);
      if (pass_d) begin
        $display("*-* All Finished *-*");
        $finish;
      end else begin
        $display("expected=%x", EXPECTED);
        $stop;
      end
    end
  end
`endif

endmodule
